onbellek_denetleyici: RTL
=========================

// Module: onbellek_denetleyici
// PURPOSE
// Direct-mapped, write-back, write-allocate data cache between the processor load/store port and the
// 256-bit line main-memory model. Processor side: 32-bit word requests, valid/ready handshake.
// Memory side: whole 32-byte lines; drives the memory model's request/response handshake directly.
// Also counts hits and misses for the branch/cache experiments.
// PARAMETERS
// SATIR_SAYISI  64  number of cache lines; power of two; index = adres[5 +: log2(SATIR_SAYISI)]
// PORTS
// clk_i                    in   1    clock
// rst_ni                   in   1    asynchronous active-low reset
// islemci_adres_i          in   32   byte address; [1:0] ignored, [4:2] word select
// islemci_veri_i           in   32   store data
// islemci_gecerli_i        in   1    request valid
// islemci_yaz_i            in   1    1=store, 0=load
// islemci_hazir_o          out  1    cache can accept a request
// islemci_yanit_veri_o     out  32   load data (store: echoes stored word)
// islemci_yanit_gecerli_o  out  1    response valid, held until accepted
// islemci_yanit_hazir_i    in   1    processor accepts response
// bellek_istek_adres_o     out  32   line address, [4:0]=0
// bellek_istek_veri_o      out  256  writeback line, byte k at [8k +: 8]
// bellek_istek_gecerli_o   out  1    memory request valid
// bellek_istek_yaz_o       out  1    1=writeback, 0=line fill
// bellek_istek_hazir_i     in   1    memory accepts request
// bellek_yanit_veri_i      in   256  fill line
// bellek_yanit_gecerli_i   in   1    fill data valid
// bellek_yanit_hazir_o     out  1    cache accepts fill data
// isabet_sayisi_o          out  32   hit counter
// iska_sayisi_o            out  32   miss counter
// BEHAVIOUR
// - Reset (async, rst_ni=0): FSM=BOSTA, all valid/dirty bits 0, all outputs 0, counters 0. Data/tag arrays
//   need not reset. Reset mid-transaction abandons it; no memory request is re-issued.
// - Storage: per line valid, dirty, tag=adres[31:5+IDX], 256-bit data; flop arrays, combinational read.
// - States: BOSTA, KARSILASTIR, GERI_YAZ, GETIR, GETIR_BEKLE, YANIT.
// - BOSTA: islemci_hazir_o=1. Handshake (hazir&gecerli) latches adres/veri/yaz -> KARSILASTIR; hazir drops next cycle.
// - KARSILASTIR: hit = valid & tag match. Hit: isabet++; load reads word; store writes word, sets dirty;
//   -> YANIT. Miss: iska++ (once per request); dirty victim -> GERI_YAZ, else -> GETIR.
// - GERI_YAZ: gecerli=1, yaz=1, adres={victim tag,index,5'b0}, veri=victim line; on hazir_i -> GETIR.
//   Victim dirty bit cleared at acceptance. No write response is expected from memory.
// - GETIR: gecerli=1, yaz=0, adres=req line addr; held until hazir_i, then deassert next cycle -> GETIR_BEKLE.
// - GETIR_BEKLE: bellek_yanit_hazir_o=1; on yanit_gecerli_i: write line, valid=1, tag set, dirty=0;
//   -> KARSILASTIR (replay; counts as hit only if not already counted as miss: counters unchanged on replay,
//   replay store then sets dirty=1).
// - YANIT: yanit_gecerli_o=1 with veri stable until yanit_hazir_i; then -> BOSTA.
// - Hit latency: request accepted at edge T -> yanit_gecerli_o high from cycle T+2.
// - bellek_yanit_hazir_o also 1 in BOSTA: stray fills (after reset) are accepted and discarded.
// - Memory request signals never change while gecerli=1 and hazir_i=0.
// - Counters wrap 2^32-1 -> 0. Only one outstanding processor request; no hit-under-miss.
// TESTING
// - Cold load 0x0000_0040 (mem word=0xDEADBEEF) -> one fill req adr 0x40, response 0xDEADBEEF, iska=1.
// - Repeat load 0x44 -> yanit_gecerli at T+2, no memory request, isabet=1.
// - Store 0xA5A5A5A5 to 0x40, then load 0x0000_0840 (same index, SATIR_SAYISI=64) -> writeback
//   adr 0x40 bytes[3:0]=A5, then fill 0x840; memory at 0x40 reads back 0xA5A5A5A5.
// - Store miss to 0x100 -> fill, merge, dirty=1; load 0x100 hits with stored word.
// - Hold yanit_hazir_i=0 10 cycles -> response stable; hazir_o stays 0 until accepted.
// - Assert rst_ni=0 in GETIR_BEKLE -> outputs 0 immediately; stray fill drained; next load misses.

Source files
------------

// File: rtl/onbellek_denetleyici.sv
// ============================================================================
// Module      : onbellek_denetleyici
// Description : Direct-mapped write-back / write-allocate data cache between a
//               32-bit processor load/store port and a 256-bit line memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onbellek_denetleyici #(
    parameter int SATIR_SAYISI = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [31:0]  islemci_adres_i,
    input  logic [31:0]  islemci_veri_i,
    input  logic         islemci_gecerli_i,
    input  logic         islemci_yaz_i,
    output logic         islemci_hazir_o,
    output logic [31:0]  islemci_yanit_veri_o,
    output logic         islemci_yanit_gecerli_o,
    input  logic         islemci_yanit_hazir_i,
    output logic [31:0]  bellek_istek_adres_o,
    output logic [255:0] bellek_istek_veri_o,
    output logic         bellek_istek_gecerli_o,
    output logic         bellek_istek_yaz_o,
    input  logic         bellek_istek_hazir_i,
    input  logic [255:0] bellek_yanit_veri_i,
    input  logic         bellek_yanit_gecerli_i,
    output logic         bellek_yanit_hazir_o,
    output logic [31:0]  isabet_sayisi_o,
    output logic [31:0]  iska_sayisi_o
);

    localparam int c_IDX_W = $clog2(SATIR_SAYISI);
    localparam int c_TAG_W = 32 - 5 - c_IDX_W;

    typedef enum logic [2:0] {
        BOSTA       = 3'd0,
        KARSILASTIR = 3'd1,
        GERI_YAZ    = 3'd2,
        GETIR       = 3'd3,
        GETIR_BEKLE = 3'd4,
        YANIT       = 3'd5
    } durum_t;

    durum_t r_durum;

    // Latched processor request
    logic [31:2] r_adres;
    logic [31:0] r_istek_veri;
    logic        r_yaz;
    logic        r_iska_sayildi;

    // Line storage
    logic [SATIR_SAYISI-1:0] r_gecerli;
    logic [SATIR_SAYISI-1:0] r_kirli;
    logic [c_TAG_W-1:0]      r_etiket [SATIR_SAYISI];
    logic [255:0]            r_veri   [SATIR_SAYISI];

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_etiket;
    logic [2:0]         w_kelime;
    logic               w_isabet;
    logic [255:0]       w_satir;
    logic [31:0]        w_okunan;
    logic               w_dolum_yaz;
    logic               w_kelime_yaz;

    assign w_idx        = r_adres[5 +: c_IDX_W];
    assign w_etiket     = r_adres[31 -: c_TAG_W];
    assign w_kelime     = r_adres[4:2];
    assign w_satir      = r_veri[w_idx];
    assign w_okunan     = w_satir[{w_kelime, 5'b0} +: 32];
    assign w_isabet     = r_gecerli[w_idx] && (r_etiket[w_idx] == w_etiket);
    assign w_dolum_yaz  = (r_durum == GETIR_BEKLE) && bellek_yanit_gecerli_i;
    assign w_kelime_yaz = (r_durum == KARSILASTIR) && w_isabet && r_yaz;

    // Tag and data arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (w_dolum_yaz) begin
            r_veri[w_idx]   <= bellek_yanit_veri_i;
            r_etiket[w_idx] <= w_etiket;
        end else if (w_kelime_yaz) begin
            r_veri[w_idx][{w_kelime, 5'b0} +: 32] <= r_istek_veri;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_durum                 <= BOSTA;
            r_adres                 <= '0;
            r_istek_veri            <= '0;
            r_yaz                   <= 1'b0;
            r_iska_sayildi          <= 1'b0;
            r_gecerli               <= '0;
            r_kirli                 <= '0;
            islemci_hazir_o         <= 1'b0;
            islemci_yanit_veri_o    <= '0;
            islemci_yanit_gecerli_o <= 1'b0;
            bellek_istek_adres_o    <= '0;
            bellek_istek_veri_o     <= '0;
            bellek_istek_gecerli_o  <= 1'b0;
            bellek_istek_yaz_o      <= 1'b0;
            bellek_yanit_hazir_o    <= 1'b0;
            isabet_sayisi_o         <= '0;
            iska_sayisi_o           <= '0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    if (islemci_gecerli_i && islemci_hazir_o) begin
                        r_adres              <= islemci_adres_i[31:2];
                        r_istek_veri         <= islemci_veri_i;
                        r_yaz                <= islemci_yaz_i;
                        r_iska_sayildi       <= 1'b0;
                        islemci_hazir_o      <= 1'b0;
                        bellek_yanit_hazir_o <= 1'b0;
                        r_durum              <= KARSILASTIR;
                    end else begin
                        // Stray fills arriving here are accepted and dropped.
                        islemci_hazir_o      <= 1'b1;
                        bellek_yanit_hazir_o <= 1'b1;
                    end
                end

                KARSILASTIR: begin
                    if (w_isabet) begin
                        if (!r_iska_sayildi) begin
                            isabet_sayisi_o <= isabet_sayisi_o + 32'd1;
                        end
                        if (r_yaz) begin
                            r_kirli[w_idx]       <= 1'b1;
                            islemci_yanit_veri_o <= r_istek_veri;
                        end else begin
                            islemci_yanit_veri_o <= w_okunan;
                        end
                        islemci_yanit_gecerli_o <= 1'b1;
                        r_durum                 <= YANIT;
                    end else begin
                        if (!r_iska_sayildi) begin
                            iska_sayisi_o <= iska_sayisi_o + 32'd1;
                        end
                        r_iska_sayildi         <= 1'b1;
                        bellek_istek_gecerli_o <= 1'b1;
                        if (r_gecerli[w_idx] && r_kirli[w_idx]) begin
                            bellek_istek_yaz_o   <= 1'b1;
                            bellek_istek_adres_o <= {r_etiket[w_idx], w_idx, 5'b0};
                            bellek_istek_veri_o  <= w_satir;
                            r_durum              <= GERI_YAZ;
                        end else begin
                            bellek_istek_yaz_o   <= 1'b0;
                            bellek_istek_adres_o <= {r_adres[31:5], 5'b0};
                            r_durum              <= GETIR;
                        end
                    end
                end

                GERI_YAZ: begin
                    // Fill request follows the accepted writeback back-to-back.
                    if (bellek_istek_hazir_i) begin
                        r_kirli[w_idx]       <= 1'b0;
                        bellek_istek_yaz_o   <= 1'b0;
                        bellek_istek_adres_o <= {r_adres[31:5], 5'b0};
                        r_durum              <= GETIR;
                    end
                end

                GETIR: begin
                    if (bellek_istek_hazir_i) begin
                        bellek_istek_gecerli_o <= 1'b0;
                        bellek_yanit_hazir_o   <= 1'b1;
                        r_durum                <= GETIR_BEKLE;
                    end
                end

                GETIR_BEKLE: begin
                    if (bellek_yanit_gecerli_i) begin
                        r_gecerli[w_idx]     <= 1'b1;
                        r_kirli[w_idx]       <= 1'b0;
                        bellek_yanit_hazir_o <= 1'b0;
                        r_durum              <= KARSILASTIR;
                    end
                end

                YANIT: begin
                    if (islemci_yanit_hazir_i) begin
                        islemci_yanit_gecerli_o <= 1'b0;
                        islemci_hazir_o         <= 1'b1;
                        bellek_yanit_hazir_o    <= 1'b1;
                        r_durum                 <= BOSTA;
                    end
                end

                default: begin
                    r_durum <= BOSTA;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
